// File: rtl/div_unit.sv
// Radix-2 restoring 32/32 divider for the E stage: DIV/DIVU producing {hi=remainder, lo=quotient}.
// Latency: 1 start cycle + 32 BUSY cycles, result registered on entry to DONE; stalls E until then.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_enE,
    input  logic        signed_divE,
    input  logic [31:0] src_aE,
    input  logic [31:0] src_bE,
    input  logic        hold_otherE,
    input  logic        flush_divE,
    output logic        div_stallE,
    output logic [63:0] div_resultE,
    output logic        div_validE
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic [31:0] dvsr;
    logic [31:0] quo;
    logic [31:0] prem;
    logic        q_neg, r_neg;

    logic        start;
    logic [31:0] a_abs, b_abs;
    logic [32:0] shifted, diff;
    logic        ge;
    logic [31:0] prem_step, quo_step;
    logic [31:0] quo_fin, rem_fin;

    assign start = (state == IDLE) & div_enE & ~flush_divE;

    assign a_abs = (signed_divE & src_aE[31]) ? -src_aE : src_aE;
    assign b_abs = (signed_divE & src_bE[31]) ? -src_bE : src_bE;

    // 33-bit partial remainder: prem shifted left with the next dividend bit.
    assign shifted   = {prem, quo[31]};
    assign diff      = shifted - {1'b0, dvsr};
    assign ge        = ~diff[32];
    assign prem_step = ge ? diff[31:0] : shifted[31:0];
    assign quo_step  = {quo[30:0], ge};

    assign quo_fin = q_neg ? -quo_step  : quo_step;
    assign rem_fin = r_neg ? -prem_step : prem_step;

    assign div_validE = (state == DONE);

    always_comb begin
        state_nxt  = state;
        div_stallE = 1'b0;
        case (state)
            IDLE: begin
                div_stallE = div_enE & ~flush_divE;
                if (start) state_nxt = BUSY;
            end
            BUSY: begin
                div_stallE = 1'b1;
                if (cnt == 6'd31) state_nxt = DONE;
            end
            DONE: begin
                if (!hold_otherE) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush_divE) begin
            state_nxt  = IDLE;
            div_stallE = 1'b0;
        end
        if (!rst) div_stallE = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 6'd0;
            dvsr        <= 32'd0;
            quo         <= 32'd0;
            prem        <= 32'd0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            div_resultE <= 64'h0;
        end else begin
            state <= state_nxt;
            if (start) begin
                dvsr  <= b_abs;
                quo   <= a_abs;
                prem  <= 32'd0;
                cnt   <= 6'd0;
                q_neg <= signed_divE & (src_aE[31] ^ src_bE[31]);
                r_neg <= signed_divE & src_aE[31];
            end else if (state == BUSY) begin
                prem <= prem_step;
                quo  <= quo_step;
                cnt  <= cnt + 6'd1;
                // Final step: a flush on this edge discards the result.
                if (cnt == 6'd31 && !flush_divE)
                    div_resultE <= {rem_fin, quo_fin};
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit against a cycle-timeline reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sgn;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hold;
    logic        flush;
    logic        stall;
    logic [63:0] result;
    logic        valid;

    int vectors    = 0;
    int miscompares = 0;

    // Model: k = -1 idle, 1..32 busy cycles, 33 done.
    int          k = -1;
    logic [63:0] pend = 64'h0;
    logic [63:0] exp_res = 64'h0;
    bit          res_zero = 1'b1;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .div_enE    (en),
        .signed_divE(sgn),
        .src_aE     (src_a),
        .src_bE     (src_b),
        .hold_otherE(hold),
        .flush_divE (flush),
        .div_stallE (stall),
        .div_resultE(result),
        .div_validE (valid)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] aa, bb, q, r;
        aa = (s && a[31]) ? 32'd0 - a : a;
        bb = (s && b[31]) ? 32'd0 - b : b;
        if (bb == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = aa;
        end else begin
            q = aa / bb;
            r = aa % bb;
        end
        if (s && (a[31] ^ b[31])) q = 32'd0 - q;
        if (s && a[31])           r = 32'd0 - r;
        return {r, q};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        logic exp_stall;
        if (!rst || flush)   exp_stall = 1'b0;
        else if (k < 0)      exp_stall = en;
        else if (k <= 32)    exp_stall = 1'b1;
        else                 exp_stall = 1'b0;
        check("stall", {63'd0, stall}, {63'd0, exp_stall});
        if (rst) begin
            check("valid", {63'd0, valid}, {63'd0, (k == 33)});
            if (k == 33) check("result", result, exp_res);
            if (res_zero) check("reset_result", result, 64'h0);
        end
        if (!rst) begin
            k = -1;
            res_zero = 1'b1;
        end else if (flush) begin
            k = -1;
        end else if (k < 0) begin
            if (en) begin
                k = 1;
                pend = ref_div(src_a, src_b, sgn);
            end
        end else if (k <= 32) begin
            k = k + 1;
            if (k == 33) begin
                exp_res = pend;
                res_zero = 1'b0;
            end
        end else if (!hold) begin
            k = -1;
        end
    end

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input int hold_n, input bit keep_en,
                           input bit chk_lit, input logic [63:0] lit);
        bit got;
        got = 1'b0;
        src_a = a; src_b = b; sgn = s; en = 1'b1; flush = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (valid) begin
                got = 1'b1;
                break;
            end
            src_a = $urandom; src_b = $urandom; hold = 1'($urandom % 2);
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: div_validE never rose for %h / %h", a, b);
            en = 1'b0; hold = 1'b0;
            @(posedge clk); #1;
            return;
        end
        if (chk_lit) check("literal", result, lit);
        for (int j = 0; j < hold_n; j++) begin
            hold = 1'b1;
            @(posedge clk); #1;
        end
        hold = 1'b0;
        @(posedge clk); #1;
        if (!keep_en) en = 1'b0;
    endtask

    task automatic flush_div(input logic [31:0] a, input logic [31:0] b, input logic s, input int r);
        src_a = a; src_b = b; sgn = s; en = 1'b1; hold = 1'b0;
        @(posedge clk); #1;
        repeat (r) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; en = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic        s;
        int          mode;
        rst = 1'b0; en = 1'b0; sgn = 1'b0; src_a = 32'd0; src_b = 32'd0;
        hold = 1'b0; flush = 1'b0;
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; en = 1'b0;
        @(posedge clk); #1;

        check("ref 100/7",       ref_div(32'd100, 32'd7, 1'b0),                {32'd2, 32'd14});
        check("ref -7/2",        ref_div(32'hFFFF_FFF9, 32'd2, 1'b1),          {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        check("ref min/-1",      ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1),  {32'd0, 32'h8000_0000});
        check("ref 5/0",         ref_div(32'd5, 32'd0, 1'b0),                  {32'd5, 32'hFFFF_FFFF});
        check("ref -5/0 signed", ref_div(32'hFFFF_FFFB, 32'd0, 1'b1),          {32'hFFFF_FFFB, 32'd1});

        run_div(32'd100, 32'd7, 1'b0, 0, 0, 1, {32'd2, 32'd14});
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0, 1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0, 1, {32'd0, 32'h8000_0000});
        run_div(32'd5, 32'd0, 1'b0, 0, 0, 1, {32'd5, 32'hFFFF_FFFF});

        flush_div(32'd100, 32'd7, 1'b0, 10);
        run_div(32'd9, 32'd3, 1'b0, 0, 0, 1, {32'd0, 32'd3});

        run_div(32'd12345, 32'd100, 1'b0, 5, 0, 1, {32'd45, 32'd123});

        // Back-to-back: enable stays high through DONE -> IDLE.
        run_div(32'd50, 32'd6, 1'b0, 0, 1, 1, {32'd2, 32'd8});
        run_div(32'hFFFF_FF9C, 32'd7, 1'b1, 0, 0, 1, {32'hFFFF_FFFE, 32'hFFFF_FFF2});

        src_a = 32'd77; src_b = 32'd5; sgn = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        repeat (20) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        run_div(32'd1000, 32'd10, 1'b0, 0, 0, 1, {32'd0, 32'd100});

        for (int n = 0; n < 40; n++) begin
            mode = int'($urandom % 8);
            s = 1'($urandom % 2);
            a = $urandom;
            b = $urandom;
            case (mode)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1; end
                2: begin a = $urandom % 1000; b = $urandom % 20; end
                3: b = $urandom % 256;
                default: ;
            endcase
            if ($urandom % 6 == 0)
                flush_div(a, b, s, int'($urandom % 33));
            else
                run_div(a, b, s, int'($urandom % 4), 1'($urandom % 2), 0, 64'h0);
        end
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
